// File: rtl/imm_gen_stage.sv
// ============================================================================
// Module : imm_gen_stage
// Brief  : ID-side immediate generator with PC-relative target and 2-entry skid buffer
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_gen_stage #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b0,
    parameter int DEPTH       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_extop,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_illegal
);

    localparam logic [2:0] c_FMT_I   = 3'b000;
    localparam logic [2:0] c_FMT_U   = 3'b001;
    localparam logic [2:0] c_FMT_S   = 3'b010;
    localparam logic [2:0] c_FMT_B   = 3'b011;
    localparam logic [2:0] c_FMT_J   = 3'b100;
    localparam logic [2:0] c_FMT_Z   = 3'b101;
    localparam logic [2:0] c_FMT_SH  = 3'b110;
    localparam logic [2:0] c_FMT_ILL = 3'b111;

    if (DEPTH != 2) begin : g_depth_bad
        $error("imm_gen_stage: DEPTH must be 2");
    end

    logic [2:0]      fmt;
    logic            rtype;
    logic [31:0]     imm32;
    logic            illegal;
    logic [XLEN-1:0] imm_x;
    logic [XLEN-1:0] target_x;

    always_comb begin
        fmt   = in_extop;
        rtype = 1'b0;
        if (AUTO_DECODE) begin
            fmt = c_FMT_ILL;
            case (in_instr[6:0])
                7'b0010011: fmt = (in_instr[13:12] == 2'b01) ? c_FMT_SH : c_FMT_I;
                7'b0000011,
                7'b1100111: fmt = c_FMT_I;
                7'b0110111,
                7'b0010111: fmt = c_FMT_U;
                7'b0100011: fmt = c_FMT_S;
                7'b1100011: fmt = c_FMT_B;
                7'b1101111: fmt = c_FMT_J;
                7'b1110011: fmt = in_instr[14] ? c_FMT_Z : c_FMT_ILL;
                7'b0110011: begin
                    fmt   = c_FMT_I;
                    rtype = 1'b1;
                end
                default:    fmt = c_FMT_ILL;
            endcase
        end
    end

    // Zero-extended formats keep bit 31 clear, so one sign-extension covers all.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (fmt)
            c_FMT_I:  imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            c_FMT_U:  imm32 = {in_instr[31:12], 12'b0};
            c_FMT_S:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            c_FMT_B:  imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
            c_FMT_J:  imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
            c_FMT_Z:  imm32 = {27'b0, in_instr[19:15]};
            c_FMT_SH: imm32 = (XLEN == 64) ? {26'b0, in_instr[25:20]}
                                           : {27'b0, in_instr[24:20]};
            default:  illegal = 1'b1;
        endcase
        if (rtype) begin
            imm32 = '0;
        end
    end

    assign imm_x    = XLEN'($signed(imm32));
    assign target_x = in_pc + imm_x;

    logic [1:0]      count_q, count_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            push, pop;
    logic [XLEN-1:0] imm_q    [DEPTH];
    logic [XLEN-1:0] target_q [DEPTH];
    logic [XLEN-1:0] pc_q     [DEPTH];
    logic [31:0]     instr_q  [DEPTH];
    logic            ill_q    [DEPTH];

    assign in_ready  = (count_q < 2'd2) && rst_n;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, (pop && !flush)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                imm_q[k]    <= '0;
                target_q[k] <= '0;
                pc_q[k]     <= '0;
                instr_q[k]  <= '0;
                ill_q[k]    <= 1'b0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                imm_q[wr_ptr_q]    <= imm_x;
                target_q[wr_ptr_q] <= target_x;
                pc_q[wr_ptr_q]     <= in_pc;
                instr_q[wr_ptr_q]  <= in_instr;
                ill_q[wr_ptr_q]    <= illegal;
            end
        end
    end

    assign out_imm     = imm_q[rd_ptr_q];
    assign out_target  = target_q[rd_ptr_q];
    assign out_pc      = pc_q[rd_ptr_q];
    assign out_instr   = instr_q[rd_ptr_q];
    assign out_illegal = ill_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
// ============================================================================
// Module : tb_imm_gen_stage
// Brief  : Directed-vector bench for imm_gen_stage (XLEN=32, extop-selected formats)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [2:0]  in_extop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_illegal;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(
        .XLEN        (32),
        .AUTO_DECODE (1'b0),
        .DEPTH       (2)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_extop    (in_extop),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_target  (out_target),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_illegal (out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for a single edge, then drop in_valid.
    task automatic beat(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] op);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        in_extop = op;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic head(input string tag, input logic [31:0] imm, input logic [31:0] tgt,
                        input logic ill);
        chk({tag, "_valid"},   {31'b0, out_valid},   32'd1);
        chk({tag, "_imm"},     out_imm,              imm);
        chk({tag, "_target"},  out_target,           tgt);
        chk({tag, "_illegal"}, {31'b0, out_illegal}, {31'b0, ill});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        in_extop  = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_imm",   out_imm,            32'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Format vectors, each visible one edge after the push
        beat(32'hFFF00093, 32'h0000_0000, 3'b000);
        head("I", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        beat(32'h12345037, 32'h0000_0000, 3'b001);
        head("U", 32'h1234_5000, 32'h1234_5000, 1'b0);
        beat(32'h0080006F, 32'h0000_0200, 3'b100);
        head("J", 32'h0000_0008, 32'h0000_0208, 1'b0);
        chk("J_pc", out_pc, 32'h0000_0200);
        beat(32'hFE000EE3, 32'h0000_0000, 3'b011);
        head("B_pc0", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        beat(32'hFE000EE3, 32'h0000_0100, 3'b011);
        head("B_pc100", 32'hFFFF_FFFC, 32'h0000_00FC, 1'b0);
        beat(32'hFE112E23, 32'h0000_0010, 3'b010);
        head("S", 32'hFFFF_FFFC, 32'h0000_000C, 1'b0);
        chk("S_instr", out_instr, 32'hFE112E23);
        beat(32'h800F8000, 32'h0000_0000, 3'b101);
        head("Z", 32'h0000_001F, 32'h0000_001F, 1'b0);
        beat(32'h41F0D093, 32'h0000_1000, 3'b110);
        head("SH", 32'h0000_001F, 32'h0000_101F, 1'b0);
        beat(32'h7FF00093, 32'hFFFF_FFF0, 3'b000);
        head("I_wrap", 32'h0000_07FF, 32'h0000_07EF, 1'b0);
        beat(32'hFFFFFFFF, 32'h0000_0040, 3'b111);
        head("ILL", 32'h0000_0000, 32'h0000_0040, 1'b1);
        tick();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: three beats against a stalled consumer
        out_ready = 1'b0;
        beat(32'h00100093, 32'h0000_0300, 3'b000);
        chk("bp1_in_ready", {31'b0, in_ready}, 32'd1);
        beat(32'h00200093, 32'h0000_0304, 3'b000);
        chk("bp2_in_ready", {31'b0, in_ready}, 32'd0);
        head("bp2_head", 32'h0000_0001, 32'h0000_0301, 1'b0);
        in_valid = 1'b1;
        in_instr = 32'h00300093;
        in_pc    = 32'h0000_0308;
        in_extop = 3'b000;
        tick();
        chk("bp3_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp3_stable",   out_imm,           32'h0000_0001);
        out_ready = 1'b1;
        tick();
        chk("bp_rel_in_ready", {31'b0, in_ready}, 32'd1);
        head("bp_rel_b2", 32'h0000_0002, 32'h0000_0306, 1'b0);
        tick();
        in_valid = 1'b0;
        head("bp_rel_b3", 32'h0000_0003, 32'h0000_030B, 1'b0);
        tick();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // Flush with a full buffer, then with one entry and an accepted-looking input
        out_ready = 1'b0;
        beat(32'h00400093, 32'h0, 3'b000);
        beat(32'h00500093, 32'h0, 3'b000);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00600093;
        tick();
        chk("fl_full_valid",    {31'b0, out_valid}, 32'd0);
        chk("fl_full_in_ready", {31'b0, in_ready},  32'd1);
        flush = 1'b0;
        beat(32'h00700093, 32'h0, 3'b000);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00800093;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_one_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("fl_drop_valid", {31'b0, out_valid}, 32'd0);
        beat(32'h00900093, 32'h0000_0020, 3'b000);
        head("fl_after", 32'h0000_0009, 32'h0000_0029, 1'b0);

        // Asynchronous reset mid-stream
        beat(32'h00A00093, 32'h0000_0050, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid",    {31'b0, out_valid}, 32'd0);
        chk("mrst_imm",      out_imm,            32'd0);
        chk("mrst_target",   out_target,         32'd0);
        chk("mrst_pc",       out_pc,             32'd0);
        chk("mrst_instr",    out_instr,          32'd0);
        chk("mrst_in_ready", {31'b0, in_ready},  32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mrst_rel_in_ready", {31'b0, in_ready}, 32'd1);
        beat(32'h00500093, 32'h0000_0080, 3'b111);
        head("mrst_ill", 32'h0000_0000, 32'h0000_0080, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
